fp_minmax_sched: RTL and testbench

Sequencer for the FPU min/max/compare group: FMIN, FMAX, FEQ, FLT, FLE. It accepts one operation at a time from the FP issue stage over a valid/ready handshake and drives a shared combinational compare core. It registers the result, tag and exception flags, and holds them until writeback accepts. It sits between FP issue and FP writeback, beside the other FPU functional units.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fp_cmp_core.sv | 75 +++++++
 rtl/fp_minmax_sched.sv | 101 ++++++++++
 tb/tb_fp_minmax_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encodings, canonical NaNs, field widths, fflags positions.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_FMIN = 3'd0,
    OP_FMAX = 3'd1,
    OP_FEQ  = 3'd2,
    OP_FLT  = 3'd3,
    OP_FLE  = 3'd4
  } fp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  localparam logic [63:0] CANON_NAN_64 = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] CANON_NAN_32 = 32'h7FC0_0000;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  function automatic int exp_w(input int bus_width);
    return (bus_width == 32) ? 8 : 11;
  endfunction

  function automatic int mant_w(input int bus_width);
    return (bus_width == 32) ? 23 : 52;
  endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// Combinational FMIN/FMAX/FEQ/FLT/FLE core; ops 5-7 behave as FMAX.
// NV generation only when FP_MINMAX_FLAGS_EN is defined, otherwise nv is tied low.
module fp_cmp_core
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic [2:0]           op,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 nv
);

  localparam int EW = exp_w(BUS_WIDTH);
  localparam int MW = mant_w(BUS_WIDTH);
  localparam logic [BUS_WIDTH-1:0] CANON_NAN =
    (BUS_WIDTH == 32) ? BUS_WIDTH'(CANON_NAN_32) : BUS_WIDTH'(CANON_NAN_64);

  logic                 s1, s2, nan1, nan2, both_zero;
  logic                 lt_total, lt, eq;
  logic [BUS_WIDTH-2:0] m1, m2;

  assign s1 = in1[BUS_WIDTH-1];
  assign s2 = in2[BUS_WIDTH-1];
  assign m1 = in1[BUS_WIDTH-2:0];
  assign m2 = in2[BUS_WIDTH-2:0];

  assign nan1 = (&in1[BUS_WIDTH-2 -: EW]) & (|in1[MW-1:0]);
  assign nan2 = (&in2[BUS_WIDTH-2 -: EW]) & (|in2[MW-1:0]);
  assign both_zero = ~(|m1) & ~(|m2);

  // Total order on sign-magnitude: puts -0 below +0, used by FMIN/FMAX only.
  assign lt_total = (s1 != s2) ? s1 : (s1 ? (m2 < m1) : (m1 < m2));
  assign lt       = lt_total & ~both_zero;
  assign eq       = (in1 == in2) | both_zero;

  always_comb begin
    result = '0;
    case (op)
      OP_FMIN: begin
        if (nan1 && nan2)  result = CANON_NAN;
        else if (nan1)     result = in2;
        else if (nan2)     result = in1;
        else               result = lt_total ? in1 : in2;
      end
      OP_FEQ:  result = {{(BUS_WIDTH-1){1'b0}}, ~nan1 & ~nan2 & eq};
      OP_FLT:  result = {{(BUS_WIDTH-1){1'b0}}, ~nan1 & ~nan2 & lt};
      OP_FLE:  result = {{(BUS_WIDTH-1){1'b0}}, ~nan1 & ~nan2 & (lt | eq)};
      default: begin
        if (nan1 && nan2)  result = CANON_NAN;
        else if (nan1)     result = in2;
        else if (nan2)     result = in1;
        else               result = lt_total ? in2 : in1;
      end
    endcase
  end

`ifdef FP_MINMAX_FLAGS_EN
  logic snan1, snan2;
  assign snan1 = nan1 & ~in1[MW-1];
  assign snan2 = nan2 & ~in2[MW-1];

  always_comb begin
    nv = 1'b0;
    case (op)
      OP_FLT, OP_FLE: nv = nan1 | nan2;
      default:        nv = snan1 | snan2;
    endcase
  end
`else
  assign nv = 1'b0;
`endif

endmodule

// File: rtl/fp_minmax_sched.sv
// Sequencer for FMIN/FMAX/FEQ/FLT/FLE: IDLE -> EXEC -> RESP, response held until accepted.
// Flags follow FP_MINMAX_FLAGS_EN in fp_cmp_core; flush kills in-flight work, rst overrides all.
module fp_minmax_sched
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [TAG_W-1:0]     req_tag,
  input  logic [BUS_WIDTH-1:0] req_rs1,
  input  logic [BUS_WIDTH-1:0] req_rs2,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0]     resp_tag,
  output logic [4:0]           resp_fflags
);

  sched_state_e         state_q, state_d;
  logic [2:0]           op_q;
  logic [TAG_W-1:0]     tag_q, rtag_q;
  logic [BUS_WIDTH-1:0] rs1_q, rs2_q, data_q;
  logic [4:0]           fflags_q, fflags_d;
  logic [BUS_WIDTH-1:0] core_result;
  logic                 core_nv;
  logic                 accept;

  fp_cmp_core #(.BUS_WIDTH(BUS_WIDTH)) u_core (
    .op     (op_q),
    .in1    (rs1_q),
    .in2    (rs2_q),
    .result (core_result),
    .nv     (core_nv)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = ~flush;
        if (req_valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          req_ready = ~flush;
          state_d   = req_valid ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  assign accept = req_valid & req_ready;

  always_comb begin
    fflags_d           = '0;
    fflags_d[FFLAG_NV] = core_nv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      tag_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      data_q   <= '0;
      rtag_q   <= '0;
      fflags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= req_op;
        tag_q <= req_tag;
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
      end
      // Result registers only change on EXEC exit, so RESP outputs hold under stall.
      if (state_q == ST_EXEC && !flush) begin
        data_q   <= core_result;
        rtag_q   <= tag_q;
        fflags_q <= fflags_d;
      end
    end
  end

  assign resp_valid  = (state_q == ST_RESP);
  assign resp_data   = data_q;
  assign resp_tag    = rtag_q;
  assign resp_fflags = fflags_q;

endmodule

// File: tb/tb_fp_minmax_sched.sv
// Self-checking bench for fp_minmax_sched (double precision), reference model uses real arithmetic.
module tb_fp_minmax_sched;

  localparam int BW = 64;
  localparam int TW = 5;
`ifdef FP_MINMAX_FLAGS_EN
  localparam bit NV_EN = 1'b1;
`else
  localparam bit NV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0]    req_op;
  logic [TW-1:0] req_tag, resp_tag;
  logic [BW-1:0] req_rs1, req_rs2, resp_data;
  logic [4:0]    resp_fflags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_minmax_sched #(.BUS_WIDTH(BW), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_tag     (req_tag),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_tag    (resp_tag),
    .resp_fflags (resp_fflags)
  );

  // Returns {fflags, data} as the specification defines the operation.
  function automatic logic [68:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    logic [4:0]  fl;
    bit na, nb, sna, snb, nv;
    real ra, rb;
    na  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    nb  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    sna = na && !a[51];
    snb = nb && !b[51];
    ra  = $bitstoreal(a);
    rb  = $bitstoreal(b);
    d   = 64'd0;
    nv  = 1'b0;
    case (op)
      3'd0: begin
        if (na && nb)                    d = 64'h7FF8_0000_0000_0000;
        else if (na)                     d = b;
        else if (nb)                     d = a;
        else if (ra == 0.0 && rb == 0.0) d = a[63] ? a : b;
        else                             d = (ra < rb) ? a : b;
        nv = sna || snb;
      end
      3'd2: begin d = {63'd0, !na && !nb && (ra == rb)}; nv = sna || snb; end
      3'd3: begin d = {63'd0, !na && !nb && (ra <  rb)}; nv = na || nb; end
      3'd4: begin d = {63'd0, !na && !nb && (ra <= rb)}; nv = na || nb; end
      default: begin
        if (na && nb)                    d = 64'h7FF8_0000_0000_0000;
        else if (na)                     d = b;
        else if (nb)                     d = a;
        else if (ra == 0.0 && rb == 0.0) d = a[63] ? b : a;
        else                             d = (ra > rb) ? a : b;
        nv = sna || snb;
      end
    endcase
    fl = (NV_EN && nv) ? 5'b10000 : 5'b00000;
    return {fl, d};
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0: v = 64'h0000_0000_0000_0000;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'h3FF0_0000_0000_0000;
      3: v = 64'hBFF0_0000_0000_0000;
      4: v = 64'h7FF0_0000_0000_0000;
      5: v = 64'hFFF0_0000_0000_0000;
      6: v = {$urandom_range(0, 1) == 1, 11'h7FF, 1'b1, 51'($urandom)};
      7: v = {$urandom_range(0, 1) == 1, 11'h7FF, 1'b0, 51'($urandom) | 51'd1};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Drives one request, waits for its response and accepts it.
  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, output logic [63:0] d, output logic [4:0] f,
                       output logic [4:0] t, output int lat);
    int n;
    req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    d = resp_data; f = resp_fflags; t = resp_tag;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    tests++; if (resp_data !== 64'd0) begin fails++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
    tests++; if (resp_tag !== 5'd0) begin fails++; $display("FAIL reset_resp_tag got %h exp 0", resp_tag); end
    tests++; if (resp_fflags !== 5'd0) begin fails++; $display("FAIL reset_fflags got %b exp 0", resp_fflags); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [8] = '{3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd2, 3'd4};
    logic [63:0] as  [8] = '{64'h3FF0000000000000, 64'h8000000000000000, 64'h8000000000000000,
                             64'h7FF0000000000001, 64'h7FF8000000000000, 64'h7FF8000000000000,
                             64'h7FF8000000000000, 64'hBFF0000000000000};
    logic [63:0] bs  [8] = '{64'h4000000000000000, 64'h0000000000000000, 64'h0000000000000000,
                             64'h3FF0000000000000, 64'h7FFC000000000000, 64'h3FF0000000000000,
                             64'h3FF0000000000000, 64'h3FF0000000000000};
    logic [63:0] ed  [8] = '{64'h4000000000000000, 64'h8000000000000000, 64'h0000000000000000,
                             64'h3FF0000000000000, 64'h7FF8000000000000, 64'd0, 64'd0, 64'd1};
    bit          env [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    logic [63:0] d;
    logic [4:0]  f, t, ef, et;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      et = 5'(i + 3);
      ef = (NV_EN && env[i]) ? 5'b10000 : 5'b00000;
      do_op(ops[i], as[i], bs[i], et, d, f, t, lat);
      tests++; if (d !== ed[i]) begin fails++; $display("FAIL directed%0d_data got %h exp %h", i, d, ed[i]); end
      tests++; if (f !== ef) begin fails++; $display("FAIL directed%0d_fflags got %b exp %b", i, f, ef); end
      tests++; if (t !== et) begin fails++; $display("FAIL directed%0d_tag got %0d exp %0d", i, t, et); end
      tests++; if (lat !== 1) begin fails++; $display("FAIL directed%0d_latency got %0d exp 1", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, d;
    logic [4:0]  f, t, tag;
    logic [2:0]  op;
    logic [68:0] exp_v;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); a = pick(); b = pick(); tag = 5'($urandom);
      exp_v = model(op, a, b);
      do_op(op, a, b, tag, d, f, t, lat);
      tests++; if ({f, d} !== exp_v) begin fails++; $display("FAIL random%0d op%0d %h,%h got %b/%h exp %b/%h", i, op, a, b, f, d, exp_v[68:64], exp_v[63:0]); end
      tests++; if (t !== tag || lat !== 1) begin fails++; $display("FAIL random%0d_tag_lat got %0d/%0d exp %0d/1", i, t, lat, tag); end
    end
  endtask

  task automatic test_backpressure();
    logic [68:0] ea, eb;
    int          n;
    ea = model(3'd0, 64'h3FF0000000000000, 64'h4000000000000000);
    eb = model(3'd4, 64'h3FF0000000000000, 64'h3FF0000000000000);
    req_op = 3'd0; req_rs1 = 64'h3FF0000000000000; req_rs2 = 64'h4000000000000000; req_tag = 5'd4;
    req_valid = 1'b1; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_op = 3'd4; req_rs2 = 64'h3FF0000000000000; req_tag = 5'd5;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL stall%0d_handshake got v=%b r=%b exp v=1 r=0", i, resp_valid, req_ready); end
      tests++; if (resp_data !== ea[63:0] || resp_tag !== 5'd4 || resp_fflags !== ea[68:64]) begin fails++; $display("FAIL stall%0d_hold got %h/%0d exp %h/4", i, resp_data, resp_tag, ea[63:0]); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1; #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL chain_req_ready got %b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL chain_exec_valid got %b exp 0", resp_valid); end
    @(posedge clk); #1;
    tests++; if (resp_valid !== 1'b1 || resp_data !== eb[63:0] || resp_tag !== 5'd5) begin fails++; $display("FAIL chain_resp got v=%b %h/%0d exp v=1 %h/5", resp_valid, resp_data, resp_tag, eb[63:0]); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    localparam int K = 10;
    logic [2:0]  ops [K];
    logic [63:0] as [K], bs [K];
    logic [73:0] q [$];
    logic [73:0] e;
    int          idx, cyc, got;
    bit          acc;
    for (int i = 0; i < K; i++) begin ops[i] = 3'($urandom_range(0, 4)); as[i] = pick(); bs[i] = pick(); end
    idx = 0; cyc = 0; got = 0;
    resp_ready = 1'b1;
    req_op = ops[0]; req_rs1 = as[0]; req_rs2 = bs[0]; req_tag = 5'd0; req_valid = 1'b1;
    while ((idx < K || q.size() > 0) && cyc < 200) begin
      if (resp_valid) begin
        got++;
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL b2b_unexpected got tag %0d exp none", resp_tag); end
        else begin
          e = q.pop_front();
          if ({resp_tag, resp_fflags, resp_data} !== e) begin fails++; $display("FAIL b2b_resp got %0d/%b/%h exp %0d/%b/%h", resp_tag, resp_fflags, resp_data, e[73:69], e[68:64], e[63:0]); end
        end
      end
      acc = req_valid && req_ready;
      if (acc) q.push_back({5'(idx), model(ops[idx], as[idx], bs[idx])});
      @(posedge clk); #1; cyc++;
      if (acc) begin
        idx++;
        if (idx < K) begin req_op = ops[idx]; req_rs1 = as[idx]; req_rs2 = bs[idx]; req_tag = 5'(idx); end
        else req_valid = 1'b0;
      end
    end
    resp_ready = 1'b0; req_valid = 1'b0;
    tests++; if (got !== K) begin fails++; $display("FAIL b2b_count got %0d exp %0d", got, K); end
    tests++; if (cyc > 2 * K + 2) begin fails++; $display("FAIL b2b_throughput got %0d cycles exp <= %0d", cyc, 2 * K + 2); end
  endtask

  task automatic test_flush();
    int n, seen;
    req_op = 3'd1; req_rs1 = 64'h3FF0000000000000; req_rs2 = 64'h0; req_tag = 5'd9; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin if (resp_valid) seen++; @(posedge clk); #1; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL flush_exec got %0d responses exp 0", seen); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL flush_idle_ready got %b exp 1", req_ready); end
    req_valid = 1'b1; flush = 1'b1; #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_same_cycle_ready got %b exp 0", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin if (resp_valid) seen++; @(posedge clk); #1; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL flush_not_accepted got %0d responses exp 0", seen); end
    resp_ready = 1'b0;
  endtask

  task automatic test_rst_in_resp();
    int n;
    req_op = 3'd0; req_rs1 = 64'h4000000000000000; req_rs2 = 64'hBFF0000000000000; req_tag = 5'd17; req_valid = 1'b1;
    resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests++; if (resp_valid !== 1'b1 || resp_data !== 64'hBFF0000000000000) begin fails++; $display("FAIL rst_pre_resp got v=%b %h exp v=1 bff0000000000000", resp_valid, resp_data); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL rst_in_resp got v=%b r=%b exp v=0 r=1", resp_valid, req_ready); end
    tests++; if (resp_data !== 64'd0 || resp_tag !== 5'd0) begin fails++; $display("FAIL rst_in_resp_data got %h/%0d exp 0/0", resp_data, resp_tag); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'd0; req_tag = '0; req_rs1 = '0; req_rs2 = '0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_rst_in_resp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
